// File: rtl/module_seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, results held until the next accepted start.
// Optional build macro DIV_EARLY_EXIT_EN: finish immediately when dividend < divisor.
module module_seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             done,
  output logic             error,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] work_next;

  // work holds the dividend bits still to be consumed; quotient bits fill in from the LSB.
  // When fits is set the difference is below the divisor, so a WIDTH-bit subtract is exact.
  always_comb begin
    shifted   = {rem, work[WIDTH-1]};
    fits      = (shifted >= {1'b0, divisor_q});
    rem_next  = fits ? (shifted[WIDTH-1:0] - divisor_q) : shifted[WIDTH-1:0];
    work_next = {work[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      work        <= '0;
      divisor_q   <= '0;
      rem         <= '0;
      cnt         <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work        <= i_dividend;
            divisor_q   <= i_divisor;
            rem         <= '0;
            cnt         <= CW'(WIDTH);
            o_quotient  <= '0;
            o_remainder <= '0;
            error       <= 1'b0;
            busy        <= 1'b1;
            if (i_divisor == '0) begin
              state       <= FINISH;
              o_quotient  <= '1;
              o_remainder <= i_dividend;
              error       <= 1'b1;
              done        <= 1'b1;
            end
`ifdef DIV_EARLY_EXIT_EN
            else if (i_dividend < i_divisor) begin
              state       <= FINISH;
              o_remainder <= i_dividend;
              done        <= 1'b1;
            end
`endif
            else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem  <= rem_next;
          work <= work_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            o_quotient  <= work_next;
            o_remainder <= rem_next;
            done        <= 1'b1;
            state       <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_seq_divider.sv
// Self-checking bench for module_seq_divider (WIDTH=8) using a scoreboard of expected results.
// Expected latency accounts for DIV_EARLY_EXIT_EN when the build defines it.
module tb_module_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] i_dividend = '0;
  logic [W-1:0] i_divisor = '0;
  logic [W-1:0] o_quotient;
  logic [W-1:0] o_remainder;
  logic         done;
  logic         error;
  logic         busy;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  module_seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .i_dividend(i_dividend), .i_divisor(i_divisor),
    .o_quotient(o_quotient), .o_remainder(o_remainder),
    .done(done), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: behavioural divide plus the expected edges from accept to done.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t x;
    if (b == '0) begin
      x.q = '1; x.r = a; x.e = 1'b1; x.lat = 1;
    end else begin
      x.q = a / b; x.r = a % b; x.e = 1'b0; x.lat = W + 1;
`ifdef DIV_EARLY_EXIT_EN
      if (a < b) x.lat = 1;
`endif
    end
    return x;
  endfunction

  // Issues one start from IDLE; returns at the falling edge after the accepting edge.
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    i_dividend = a;
    i_divisor  = b;
    start      = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; lat counts edges from the accepting edge inclusive.
  task automatic wait_done(output bit seen, output int lat,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic e);
    seen = 1'b0; lat = 1; q = '0; r = '0; e = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1; q = o_quotient; r = o_remainder; e = error;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    int dones;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({o_quotient, o_remainder, done, error, busy} !== '0)
      $display("[TB] FAIL reset_outputs: got q=%0d r=%0d done=%b err=%b busy=%b, want all 0",
               o_quotient, o_remainder, done, error, busy);
    else passed++;
    dones = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dones++;
    end
    checks++;
    if (dones !== 0) $display("[TB] FAIL reset_idle: %0d cycles with done/busy, want 0", dones);
    else passed++;
  endtask

  task automatic test_basic();
    bit seen; int lat; logic [W-1:0] q, r; logic e; exp_t x;
    int bad;
    drive_op(8'd200, 8'd7);
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL basic_busy: got %b, want 1", busy);
    else passed++;
    wait_done(seen, lat, q, r, e);
    x = sb.pop_front();
    checks++;
    if (!seen) $display("[TB] FAIL basic_timeout: no done within bound");
    else passed++;
    checks++;
    if ({q, r, e} !== {x.q, x.r, x.e})
      $display("[TB] FAIL basic_result: got %0d r%0d e%b, want %0d r%0d e%b", q, r, e, x.q, x.r, x.e);
    else passed++;
    checks++;
    if (lat !== x.lat) $display("[TB] FAIL basic_latency: got %0d, want %0d", lat, x.lat);
    else passed++;
    bad = 0;
    repeat (50) begin
      i_dividend = W'($urandom);
      i_divisor  = W'($urandom);
      @(posedge clk); @(negedge clk);
      if (done !== 1'b0 || o_quotient !== x.q || o_remainder !== x.r || error !== x.e) bad++;
    end
    checks++;
    if (bad !== 0) $display("[TB] FAIL basic_hold: %0d cycles changed or done repeated, want 0", bad);
    else passed++;
  endtask

  task automatic test_div_zero();
    bit seen; int lat; logic [W-1:0] q, r; logic e; exp_t x;
    logic [W-1:0] ops[2][2];
    ops[0][0] = 8'd45; ops[0][1] = 8'd0;
    ops[1][0] = 8'd9;  ops[1][1] = 8'd3;
    for (int k = 0; k < 2; k++) begin
      drive_op(ops[k][0], ops[k][1]);
      wait_done(seen, lat, q, r, e);
      x = sb.pop_front();
      checks++;
      if (!seen || {q, r, e} !== {x.q, x.r, x.e})
        $display("[TB] FAIL divzero_result[%0d]: got seen=%b %0d r%0d e%b, want %0d r%0d e%b",
                 k, seen, q, r, e, x.q, x.r, x.e);
      else passed++;
      checks++;
      if (lat !== x.lat) $display("[TB] FAIL divzero_latency[%0d]: got %0d, want %0d", k, lat, x.lat);
      else passed++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_boundary();
    bit seen; int lat; logic [W-1:0] q, r; logic e; exp_t x;
    logic [W-1:0] ops[4][2];
    ops[0][0] = 8'd255; ops[0][1] = 8'd1;
    ops[1][0] = 8'd0;   ops[1][1] = 8'd5;
    ops[2][0] = 8'd255; ops[2][1] = 8'd255;
    ops[3][0] = 8'd3;   ops[3][1] = 8'd200;
    for (int k = 0; k < 4; k++) begin
      drive_op(ops[k][0], ops[k][1]);
      wait_done(seen, lat, q, r, e);
      x = sb.pop_front();
      checks++;
      if (!seen || {q, r, e} !== {x.q, x.r, x.e})
        $display("[TB] FAIL boundary_result[%0d/%0d]: got seen=%b %0d r%0d e%b, want %0d r%0d e%b",
                 ops[k][0], ops[k][1], seen, q, r, e, x.q, x.r, x.e);
      else passed++;
      checks++;
      if (lat !== x.lat)
        $display("[TB] FAIL boundary_latency[%0d/%0d]: got %0d, want %0d", ops[k][0], ops[k][1], lat, x.lat);
      else passed++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    bit seen; int lat; logic [W-1:0] q, r; logic e; exp_t x;
    int extra;
    drive_op(8'd250, 8'd6);
    @(posedge clk); @(negedge clk);
    i_dividend = 8'd100; i_divisor = 8'd10; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    wait_done(seen, lat, q, r, e);
    x = sb.pop_front();
    checks++;
    if (!seen || {q, r, e} !== {x.q, x.r, x.e})
      $display("[TB] FAIL ignore_result: got seen=%b %0d r%0d e%b, want %0d r%0d e%b",
               seen, q, r, e, x.q, x.r, x.e);
    else passed++;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    extra = 0;
    repeat (20) begin
      if (done !== 1'b0 || busy !== 1'b0) extra++;
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (extra !== 0 || o_quotient !== x.q || o_remainder !== x.r)
      $display("[TB] FAIL ignore_no_second_op: %0d busy/done cycles, q=%0d r=%0d, want 0 and %0d r%0d",
               extra, o_quotient, o_remainder, x.q, x.r);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int done_cyc[$];
    int cyc;
    int bad_q;
    exp_t x;
    x = model(8'd9, 8'd3);
    @(negedge clk);
    i_dividend = 8'd9; i_divisor = 8'd3; start = 1'b1;
    cyc = 0; bad_q = 0;
    repeat (35) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        done_cyc.push_back(cyc);
        if (o_quotient !== x.q || o_remainder !== x.r) bad_q++;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 40 && busy !== 1'b0; i++) begin
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (done_cyc.size() < 3)
      $display("[TB] FAIL b2b_count: got %0d done pulses, want 3", done_cyc.size());
    else begin
      passed++;
      checks++;
      if (done_cyc[1] - done_cyc[0] !== W + 2 || done_cyc[2] - done_cyc[1] !== W + 2)
        $display("[TB] FAIL b2b_spacing: got %0d,%0d, want %0d", done_cyc[1] - done_cyc[0],
                 done_cyc[2] - done_cyc[1], W + 2);
      else passed++;
    end
    checks++;
    if (bad_q !== 0) $display("[TB] FAIL b2b_result: %0d wrong results, want 0", bad_q);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL b2b_drain: busy=%b, want 0", busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit seen; int lat; logic [W-1:0] q, r; logic e; exp_t x;
    int stray;
    drive_op(8'd200, 8'd7);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    sb.delete();
    checks++;
    if ({o_quotient, o_remainder, done, error, busy} !== '0)
      $display("[TB] FAIL midreset_outputs: got q=%0d r=%0d done=%b err=%b busy=%b, want all 0",
               o_quotient, o_remainder, done, error, busy);
    else passed++;
    stray = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (done !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) $display("[TB] FAIL midreset_no_done: got %0d done cycles, want 0", stray);
    else passed++;
    drive_op(8'd17, 8'd5);
    wait_done(seen, lat, q, r, e);
    x = sb.pop_front();
    checks++;
    if (!seen || {q, r, e} !== {x.q, x.r, x.e})
      $display("[TB] FAIL midreset_next: got seen=%b %0d r%0d e%b, want %0d r%0d e%b",
               seen, q, r, e, x.q, x.r, x.e);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_boundary();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
